// File: rtl/ac2_pkg.sv
// Shared types and width helpers for the ac2 accumulate path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ac2_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} ac2_state_t;

  localparam int AC2_LANES = 4;

  // Mux data width: enough for a sum of M products of Pa-bit operands, plus sign.
  function automatic int ac2_w(input int m, input int pa);
    return $clog2(m) + pa + 1;
  endfunction

  // Accumulator width: N additions of a W-bit signed value cannot overflow.
  function automatic int ac2_aw(input int w, input int n);
    return w + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ac2_lane_acc.sv
// One lane accumulator: AW-bit register adding the sign-extended mux value.
// Latency: sum visible one edge after en.
// Backpressure: none; holds whenever en is low.
module ac2_lane_acc #(
  parameter int W  = 13,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [W-1:0]  mux_in,
  output logic [AW-1:0] acc
);

  logic [AW-1:0] addend;

  assign addend = {{(AW-W){mux_in[W-1]}}, mux_in};

  // Clear dominates add; the add wraps modulo 2^AW by construction.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/ac2_accum_seq.sv
// Round-robin 4-lane accumulator sequencing the ac2_mux select over N steps.
// Latency: start at edge 0, beats at edges 1..4N, out_valid after edge 4N (+1 per stall).
// Backpressure: in_valid=0 stalls in ACCUM; result held in DONE until out_ready.
module ac2_accum_seq
  import ac2_pkg::*;
#(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int N  = 4,
  localparam int W  = ac2_w(M, Pa),
  localparam int AW = ac2_aw(W, N)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [W-1:0]                  mux_in,
  output logic [1:0]                    sel_w_en,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [AC2_LANES*AW-1:0]       acc_out
);

  localparam int             SW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0]  LAST_STEP = SW'(N - 1);
  localparam logic [1:0]     LAST_LANE = 2'(AC2_LANES - 1);

  ac2_state_t     state_q;
  ac2_state_t     state_d;
  logic [1:0]     sel_d;
  logic [SW-1:0]  step_q;
  logic [SW-1:0]  step_d;
  logic           clr_acc;
  logic           add_en;

  // Next state, select/step advance and accumulator controls.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_w_en;
    step_d  = step_q;
    clr_acc = 1'b0;
    add_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          sel_d   = '0;
          step_d  = '0;
          clr_acc = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          add_en = 1'b1;
          sel_d  = sel_w_en + 2'd1;
          if (sel_w_en == LAST_LANE) begin
            if (step_q == LAST_STEP) begin
              state_d = DONE;
              step_d  = '0;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        // start here (even on the handshake edge) is deliberately dropped.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, select, step and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_w_en  <= '0;
      step_q    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_w_en  <= sel_d;
      step_q    <= step_d;
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  for (genvar k = 0; k < AC2_LANES; k++) begin : g_lane
    ac2_lane_acc #(
      .W  (W),
      .AW (AW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_acc),
      .en     (add_en && (sel_w_en == 2'(k))),
      .mux_in (mux_in),
      .acc    (acc_out[k*AW +: AW])
    );
  end

endmodule

// File: tb/tb_ac2_accum_seq.sv
// Scoreboarded bench for ac2_accum_seq with a behavioural lane-sum model.
// Latency: n/a.
// Backpressure: exercises stalls and held out_ready.
module tb_ac2_accum_seq;
  import ac2_pkg::*;

  localparam int M  = 16;
  localparam int PA = 8;
  localparam int N  = 4;
  localparam int W  = ac2_w(M, PA);
  localparam int AW = ac2_aw(W, N);
  localparam int NB = 4 * N;
  localparam int RW = 4 * AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  mux_in;
  logic [1:0]    sel_w_en;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] acc_out;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  ac2_accum_seq #(.M(M), .Pa(PA), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .mux_in    (mux_in),
    .sel_w_en  (sel_w_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("result_without_expectation", RW'(1), RW'(0));
        end else begin
          check("lane_sums", acc_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rnd_w();
    return W'($urandom);
  endfunction

  // mode: 0 all ones, 1 lane2=-3 others +5, 2 max positive, 3 random.
  task automatic run_job(input int mode, input int stall_pct, input int bp_cycles, input int abort_after);
    int vals[NB];
    int sums[4];
    logic [RW-1:0] e;
    int b;
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0:       vals[i] = 1;
        1:       vals[i] = ((i % 4) == 2) ? -3 : 5;
        2:       vals[i] = 4095;
        default: vals[i] = int'($urandom_range(0, 8191)) - 4096;
      endcase
    end
    for (int k = 0; k < 4; k++) begin
      sums[k] = 0;
      for (int s = 0; s < N; s++) sums[k] += vals[4*s + k];
      e[k*AW +: AW] = AW'(sums[k]);
    end
    if (abort_after < 0) exp_q.push_back(e);

    // Start edge; a coincident in_valid in IDLE must not be accumulated.
    start     = 1'b1;
    in_valid  = 1'b1;
    mux_in    = rnd_w();
    out_ready = (bp_cycles == 0);
    @(posedge clk); #1;
    start = 1'b0;

    b = 0;
    while (b < NB) begin
      if (abort_after >= 0 && b == abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("abort_acc_out", acc_out, RW'(0));
        check("abort_sel", RW'(sel_w_en), RW'(0));
        check("abort_busy", RW'(busy), RW'(0));
        check("abort_out_valid", RW'(out_valid), RW'(0));
        return;
      end
      check("busy_in_accum", RW'(busy), RW'(1));
      check("out_valid_early", RW'(out_valid), RW'(0));
      if (int'($urandom_range(0, 99)) < stall_pct) begin
        in_valid = 1'b0;
        mux_in   = rnd_w();
      end else begin
        check("sel_w_en", RW'(sel_w_en), RW'(b % 4));
        in_valid = 1'b1;
        mux_in   = W'(vals[b]);
        b++;
      end
      @(posedge clk); #1;
    end

    // In DONE: garbage beats must be ignored.
    in_valid = 1'b1;
    mux_in   = rnd_w();
    check("out_valid_at_done", RW'(out_valid), RW'(1));
    check("sel_after_last", RW'(sel_w_en), RW'(0));

    for (int i = 0; i < bp_cycles; i++) begin
      start = ((i % 3) == 0);
      @(posedge clk); #1;
      start = 1'b0;
      check("bp_out_valid", RW'(out_valid), RW'(1));
      check("bp_acc_stable", acc_out, e);
    end

    out_ready = 1'b1;
    start     = (bp_cycles > 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("out_valid_drop", RW'(out_valid), RW'(0));
    check("busy_idle", RW'(busy), RW'(0));
    check("acc_retained", acc_out, e);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_ignores_beats", acc_out, e);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    mux_in    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_acc_out", acc_out, RW'(0));
    check("reset_sel", RW'(sel_w_en), RW'(0));
    check("reset_busy", RW'(busy), RW'(0));
    check("reset_out_valid", RW'(out_valid), RW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(3, 0, 0, 8);      // reset at step 2
    run_job(0, 0, 0, -1);     // each lane = 4
    run_job(1, 0, 0, -1);     // lane2 = -12, others = 20
    run_job(2, 0, 0, -1);     // 16380 per lane
    run_job(0, 30, 0, -1);    // stalls, same sums as no-stall run
    run_job(1, 30, 10, -1);   // held out_ready with ignored starts
    for (int r = 0; r < 8; r++) begin
      run_job(3, 25, int'($urandom_range(0, 3)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", RW'(exp_q.size()), RW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
